relay_update_ctrl: RTL

RELAY_UPDATE_CTRL -- requirements
Module: relay_update_ctrl

---
 rtl/relay_update_ctrl_pkg.sv | 21 ++
 rtl/relay_update_ctrl_timer.sv | 30 +++
 rtl/relay_update_ctrl.sv | 185 ++++++++++++++++++
 3 files changed

// File: rtl/relay_update_ctrl_pkg.sv
// Shared types and default constants for the relay image update controller.
// Optional feature macro used by the controller: RELAY_BBM_EN (break-before-make).
package relay_update_ctrl_pkg;

    typedef enum logic [2:0] {
        ST_IDLE   = 3'd0,
        ST_SEND   = 3'd1,
        ST_WAIT   = 3'd2,
        ST_SETTLE = 3'd3,
        ST_FINISH = 3'd4
    } state_t;

    localparam int DEF_WIDTH       = 16;
    localparam int DEF_SETTLE_CYC  = 2000;
    localparam int DEF_TIMEOUT_CYC = 65535;

    function automatic int max_int(input int a, input int b);
        return (a > b) ? a : b;
    endfunction

endpackage

// File: rtl/relay_update_ctrl_timer.sv
// relay_cycle_timer: loadable saturating down-counter; expired pulses in the
// cycle the count sits at 1, i.e. load_val cycles after the load cycle.
module relay_cycle_timer #(
    parameter int CNT_W = 16
) (
    input  logic             clk,
    input  logic             reset_n,
    input  logic             load,
    input  logic [CNT_W-1:0] load_val,
    output logic             expired
);

    logic [CNT_W-1:0] cnt_r;

    // Count register: load wins, otherwise count down and hold at zero.
    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            cnt_r <= '0;
        end else if (load) begin
            cnt_r <= load_val;
        end else if (cnt_r != '0) begin
            cnt_r <= cnt_r - CNT_W'(1);
        end else begin
            cnt_r <= cnt_r;
        end
    end

    assign expired = (cnt_r == CNT_W'(1)) && !load;

endmodule

// File: rtl/relay_update_ctrl.sv
// Relay image update controller: arbitrates safe/host requests and drives one or
// two serializer frames per update. Macro RELAY_BBM_EN enables break-before-make.
module relay_update_ctrl
    import relay_update_ctrl_pkg::*;
#(
    parameter int WIDTH       = DEF_WIDTH,
    parameter int SETTLE_CYC  = DEF_SETTLE_CYC,
    parameter int TIMEOUT_CYC = DEF_TIMEOUT_CYC
) (
    input  logic             clk,
    input  logic             reset_n,
    input  logic             host_req,
    input  logic [WIDTH-1:0] host_data,
    output logic             host_ack,
    input  logic             safe_req,
    output logic             ser_start,
    output logic [WIDTH-1:0] ser_data,
    input  logic             ser_done,
    output logic [WIDTH-1:0] cur_image,
    output logic             busy,
    output logic             err,
    input  logic             err_clr
);

    localparam int CNT_MAX = max_int(SETTLE_CYC, TIMEOUT_CYC);
    localparam int CNT_W   = $clog2(CNT_MAX + 1);

    state_t           state_r, state_s;
    logic [WIDTH-1:0] cur_image_s, ser_data_s, req_target_s;
    logic             req_host_s, grant_r, grant_s;
    logic             cur_valid_r, cur_valid_s;
    logic             err_s, host_ack_s, ser_start_s, busy_s;
    logic             tmr_load_s, tmr_expired_s;
    logic [CNT_W-1:0] tmr_val_s;
`ifdef RELAY_BBM_EN
    logic [WIDTH-1:0] target_r, target_s, brk_s;
    logic             final_r, final_s;
`endif

    relay_cycle_timer #(.CNT_W(CNT_W)) u_timer (
        .clk      (clk),
        .reset_n  (reset_n),
        .load     (tmr_load_s),
        .load_val (tmr_val_s),
        .expired  (tmr_expired_s)
    );

    // Next-state and next-output logic for the update sequencer.
    always_comb begin
        state_s     = state_r;
        cur_image_s = cur_image;
        ser_data_s  = ser_data;
        grant_s     = grant_r;
        cur_valid_s = cur_valid_r;
        err_s       = err_clr ? 1'b0 : err;
        tmr_load_s  = 1'b0;
        tmr_val_s   = CNT_W'(TIMEOUT_CYC);
`ifdef RELAY_BBM_EN
        target_s    = target_r;
        final_s     = final_r;
`endif
        if (safe_req) begin
            req_target_s = '0;
            req_host_s   = 1'b0;
        end else begin
            req_target_s = host_data;
            req_host_s   = 1'b1;
        end
`ifdef RELAY_BBM_EN
        brk_s = cur_image & req_target_s;
`endif

        case (state_r)
            ST_IDLE: begin
                if (safe_req || host_req) begin
                    grant_s = req_host_s;
`ifdef RELAY_BBM_EN
                    target_s = req_target_s;
`endif
                    // An image is only trusted once a frame has completed since reset.
                    if (cur_valid_r && (req_target_s == cur_image)) begin
                        state_s = ST_FINISH;
                    end else begin
                        state_s = ST_SEND;
`ifdef RELAY_BBM_EN
                        if (cur_valid_r && (brk_s != cur_image) && (brk_s != req_target_s)) begin
                            ser_data_s = brk_s;
                            final_s    = 1'b0;
                        end else begin
                            ser_data_s = req_target_s;
                            final_s    = 1'b1;
                        end
`else
                        ser_data_s = req_target_s;
`endif
                    end
                end else begin
                    state_s = ST_IDLE;
                end
            end
            ST_SEND: begin
                tmr_load_s = 1'b1;
                tmr_val_s  = CNT_W'(TIMEOUT_CYC);
                state_s    = ST_WAIT;
            end
            ST_WAIT: begin
                if (ser_done) begin
                    cur_image_s = ser_data;
                    cur_valid_s = 1'b1;
`ifdef RELAY_BBM_EN
                    if (final_r) begin
                        state_s = ST_FINISH;
                    end else begin
                        tmr_load_s = 1'b1;
                        tmr_val_s  = CNT_W'(SETTLE_CYC);
                        state_s    = ST_SETTLE;
                    end
`else
                    state_s = ST_FINISH;
`endif
                end else if (tmr_expired_s) begin
                    err_s   = 1'b1;
                    state_s = ST_FINISH;
                end else begin
                    state_s = ST_WAIT;
                end
            end
`ifdef RELAY_BBM_EN
            ST_SETTLE: begin
                if (tmr_expired_s) begin
                    ser_data_s = target_r;
                    final_s    = 1'b1;
                    state_s    = ST_SEND;
                end else begin
                    state_s = ST_SETTLE;
                end
            end
`endif
            ST_FINISH: begin
                state_s = ST_IDLE;
            end
            default: begin
                state_s = ST_IDLE;
            end
        endcase

        host_ack_s  = (state_s == ST_FINISH) && grant_s;
        ser_start_s = (state_s == ST_SEND);
        busy_s      = (state_s != ST_IDLE);
    end

    // State and registered outputs.
    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            state_r     <= ST_IDLE;
            cur_image   <= '0;
            ser_data    <= '0;
            grant_r     <= 1'b0;
            cur_valid_r <= 1'b0;
            err         <= 1'b0;
            host_ack    <= 1'b0;
            ser_start   <= 1'b0;
            busy        <= 1'b0;
`ifdef RELAY_BBM_EN
            target_r    <= '0;
            final_r     <= 1'b0;
`endif
        end else begin
            state_r     <= state_s;
            cur_image   <= cur_image_s;
            ser_data    <= ser_data_s;
            grant_r     <= grant_s;
            cur_valid_r <= cur_valid_s;
            err         <= err_s;
            host_ack    <= host_ack_s;
            ser_start   <= ser_start_s;
            busy        <= busy_s;
`ifdef RELAY_BBM_EN
            target_r    <= target_s;
            final_r     <= final_s;
`endif
        end
    end

endmodule
